// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock: result WIDTH+1 cycles after accept (1 for b==0).
// Start is sampled only in IDLE and is never queued; done is a one-cycle decode of the DONE state.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dbz
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] qs_q, qs_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dbz_q, dbz_d;

    // One restoring step on {p, qs}.
    logic [WIDTH:0]   p_sh;
    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH:0]   p_nxt;
    logic [WIDTH-1:0] qs_nxt;

    assign p_sh   = {p_q[WIDTH-1:0], qs_q[WIDTH-1]};
    assign trial  = p_sh - {1'b0, dvs_q};
    assign fits   = ~trial[WIDTH];
    assign p_nxt  = fits ? trial : p_sh;
    assign qs_nxt = {qs_q[WIDTH-2:0], fits};

    // p always stays below the divisor, so its MSB is zero whenever it shifts out.
    logic unused_p_msb;
    assign unused_p_msb = p_q[WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        qs_d    = qs_q;
        p_d     = p_q;
        dvs_d   = dvs_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (b != '0) begin
                        qs_d    = a;
                        dvs_d   = b;
                        p_d     = '0;
                        cnt_d   = CNT_INIT;
                        dbz_d   = 1'b0;
                        state_d = S_CALC;
                    end else begin
                        q_d     = '1;
                        r_d     = a;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_CALC: begin
                p_d   = p_nxt;
                qs_d  = qs_nxt;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    q_d     = qs_nxt;
                    r_d     = p_nxt[WIDTH-1:0];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            qs_q    <= '0;
            p_q     <= '0;
            dvs_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qs_q    <= qs_d;
            p_q     <= p_d;
            dvs_q   <= dvs_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy = (state_q == S_CALC);
    assign done = (state_q == S_DONE);
    assign q    = q_q;
    assign r    = r_q;
    assign dbz  = dbz_q;

endmodule
